// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the RV32 run controller: FSM state encoding and the halt idiom.
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_LOADED  = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } run_state_t;

  // beq x0,x0,0 : the core spins on itself forever
  localparam logic [31:0] HALT_INST = 32'h0000_0063;

endpackage

`default_nettype wire

// File: rtl/cpu_run_ctrl_if.sv
// Program-load stream plus the instruction-memory write port it produces.
`default_nettype none

interface cpu_run_ctrl_if #(
  parameter int IMEM_WORDS = 256
) ();

  localparam int AW = $clog2(IMEM_WORDS);

  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// Run controller: loads a program into imem under core reset, runs it, counts
// retired instructions and stops on the halt idiom or a cycle limit.
`default_nettype none

module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  cpu_run_ctrl_if.slave    load_bus,
  input  wire logic        start,
  input  wire logic        abort,
  input  wire logic        clear,
  output logic             cpu_rst,
  input  wire logic [31:0] inst_data,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             load_err,
  output logic [31:0]      cycle_count
);

  localparam int            AW       = $clog2(IMEM_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(IMEM_WORDS - 1);

  run_state_t    r_state;
  run_state_t    w_next;
  logic [AW-1:0] r_word_cnt;
  logic          r_load_err;
  logic [31:0]   r_cycle_count;
  logic          r_cpu_rst;

  logic          w_ld_ready;
  logic          w_xfer;
  logic          w_halt;
  logic [31:0]   w_count_inc;

  assign w_ld_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign w_xfer      = load_bus.ld_valid && w_ld_ready && !abort;
  assign w_halt      = (inst_data == HALT_INST);
  assign w_count_inc = r_cycle_count + 32'd1;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_xfer) w_next = load_bus.ld_last ? ST_LOADED : ST_LOAD;
      end
      ST_LOAD: begin
        if (w_xfer && (load_bus.ld_last || r_word_cnt == LAST_IDX)) w_next = ST_LOADED;
      end
      ST_LOADED: begin
        if (start) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_halt)                         w_next = ST_DONE;
        else if (w_count_inc == MAX_CYCLES) w_next = ST_TIMEOUT;
      end
      ST_DONE, ST_TIMEOUT: begin
        if (clear) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cpu_rst     <= 1'b1;
      r_word_cnt    <= '0;
      r_load_err    <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state   <= w_next;
      r_cpu_rst <= !(w_next == ST_RUN || w_next == ST_DONE);

      // Returning to IDLE rewinds the write pointer so the next load starts at 0.
      if (w_next == ST_IDLE)
        r_word_cnt <= '0;
      else if (w_xfer)
        r_word_cnt <= r_word_cnt + AW'(1);

      if (w_xfer && r_state == ST_IDLE)
        r_load_err <= 1'b0;
      else if (w_xfer && r_state == ST_LOAD && !load_bus.ld_last && r_word_cnt == LAST_IDX)
        r_load_err <= 1'b1;

      if (r_state == ST_LOADED && start && !abort)
        r_cycle_count <= '0;
      else if (r_state == ST_RUN && !abort && !w_halt)
        r_cycle_count <= w_count_inc;
    end
  end

  assign load_bus.ld_ready   = w_ld_ready;
  assign load_bus.imem_we    = w_xfer;
  assign load_bus.imem_addr  = r_word_cnt;
  assign load_bus.imem_wdata = load_bus.ld_data;

  assign cpu_rst     = r_cpu_rst;
  assign busy        = (r_state == ST_LOAD) || (r_state == ST_LOADED) || (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign timeout     = (r_state == ST_TIMEOUT);
  assign load_err    = r_load_err;
  assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl with a fetch model standing in for the core.
`default_nettype none

module tb_cpu_run_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int WORDS = 4;
  localparam int MAXC  = 10;
  localparam int AW    = $clog2(WORDS);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start, abort, clear;
  logic [31:0] inst_data;
  logic        cpu_rst, busy, done, timeout, load_err;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.IMEM_WORDS(WORDS)) bus ();

  cpu_run_ctrl #(.IMEM_WORDS(WORDS), .MAX_CYCLES(32'(MAXC))) dut (
    .clk(clk), .rst(rst), .load_bus(bus), .start(start), .abort(abort), .clear(clear),
    .cpu_rst(cpu_rst), .inst_data(inst_data), .busy(busy), .done(done), .timeout(timeout),
    .load_err(load_err), .cycle_count(cycle_count)
  );

  // Instruction memory and a core that fetches sequentially from PC 0 out of reset.
  logic [31:0]   imem [WORDS] = '{default: 32'h0000_0013};
  logic [AW-1:0] pc = '0;
  always @(posedge clk) begin
    if (bus.imem_we) imem[bus.imem_addr] <= bus.imem_wdata;
    if (cpu_rst) pc <= '0;
    else         pc <= pc + AW'(1);
  end
  assign inst_data = imem[pc];

  typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic is_to; logic [31:0] cnt; } res_t;

  wr_t         wr_q[$];
  res_t        res_q[$];
  logic [31:0] model_mem [WORDS] = '{default: 32'h0000_0013};
  int          vectors = 0;
  int          miscompares = 0;
  logic        prev_term = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write and every terminal event is matched against the queues.
  always @(negedge clk) begin
    wr_t  ew;
    res_t er;
    if (bus.imem_we) begin
      if (wr_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        ew = wr_q.pop_front();
        check("write_addr", 32'(bus.imem_addr), 32'(ew.addr));
        check("write_data", bus.imem_wdata, ew.data);
      end
    end
    if ((done || timeout) && !prev_term) begin
      if (res_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_end: got done=%0b timeout=%0b expected still running", done, timeout);
      end else begin
        er = res_q.pop_front();
        check("end_timeout", 32'(timeout), 32'(er.is_to));
        check("end_done", 32'(done), 32'(!er.is_to));
        check("end_count", cycle_count, er.cnt);
        check("end_cpu_rst", 32'(cpu_rst), 32'(er.is_to));
      end
    end
    prev_term <= done || timeout;
  end

  // Reference: the core executes word i%WORDS on run step i; the first halt ends it.
  function automatic res_t predict();
    for (int i = 0; i < MAXC; i++)
      if (model_mem[i % WORDS] == HALT_INST) return '{1'b0, 32'(i)};
    return '{1'b1, 32'(MAXC)};
  endfunction

  function automatic logic [31:0] rand_word(input bit allow_halt);
    logic [31:0] w;
    w = $urandom;
    if (w == HALT_INST) w = w ^ 32'h1;
    if (allow_halt && $urandom_range(0, 2) == 0) w = HALT_INST;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input logic [31:0] words[$], input bit with_last);
    int n;
    n = words.size();
    for (int i = 0; i < n; i++) begin
      bit acc;
      acc = (i < WORDS);
      if (acc) begin
        wr_q.push_back('{AW'(i), words[i]});
        model_mem[i] = words[i];
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = words[i];
      bus.ld_last  = with_last && (i == n - 1);
      check("ld_ready", 32'(bus.ld_ready), 32'(acc));
      step();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    check("load_err", 32'(load_err), 32'(!with_last));
    check("state_loaded", 32'(dut.r_state), 32'(ST_LOADED));
  endtask

  task automatic run_prog(output res_t exp);
    int k;
    exp = predict();
    res_q.push_back(exp);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!(done || timeout) && k < 3 * MAXC) begin
      step();
      k++;
    end
    if (!(done || timeout)) begin
      vectors++; miscompares++;
      $display("FAIL run_end_wait: got no done/timeout expected one within %0d cycles", 3 * MAXC);
    end
    step();
  endtask

  task automatic clear_idle(input logic [31:0] held);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_state", 32'(dut.r_state), 32'(ST_IDLE));
    check("clear_count_held", cycle_count, held);
  endtask

  initial begin
    logic [31:0] q[$];
    res_t        r;
    start = 0; abort = 0; clear = 0;
    bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;

    step(); step();
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    check("rst_imem_we", 32'(bus.imem_we), 32'd0);
    check("rst_count", cycle_count, 32'd0);
    check("rst_flags", {29'd0, busy, done, timeout}, 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    rst = 1'b0;
    step();

    // Directed program: addi x1,x0,5 ; addi x2,x1,1 ; halt
    q = {32'h0050_0093, 32'h0010_8113, HALT_INST};
    load_prog(q, 1'b1);
    run_prog(r);
    check("directed_count", cycle_count, 32'd2);
    clear_idle(32'd2);
    clear_idle(32'd2);

    // Overflow with no halt anywhere in memory also exercises the timeout
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(rand_word(1'b0));
    load_prog(q, 1'b0);
    run_prog(r);
    check("timeout_count", cycle_count, 32'(MAXC));
    clear_idle(32'(MAXC));

    // Abort during a load: no write in the abort cycle
    wr_q.push_back('{AW'(0), 32'h1234_5677});
    model_mem[0] = 32'h1234_5677;
    bus.ld_valid = 1'b1; bus.ld_data = 32'h1234_5677; bus.ld_last = 1'b0;
    step();
    bus.ld_data = 32'hDEAD_BEEF; abort = 1'b1;
    #1;
    check("abort_load_we", 32'(bus.imem_we), 32'd0);
    step();
    abort = 1'b0; bus.ld_valid = 1'b0;
    check("abort_load_state", 32'(dut.r_state), 32'(ST_IDLE));

    // Abort beats start in LOADED
    q = {rand_word(1'b0)};
    load_prog(q, 1'b1);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_start_state", 32'(dut.r_state), 32'(ST_IDLE));
    check("abort_start_cpu_rst", 32'(cpu_rst), 32'd1);
    check("abort_start_count", cycle_count, 32'(MAXC));

    // Abort mid-run
    q = {};
    for (int i = 0; i < WORDS; i++) q.push_back(rand_word(1'b0));
    load_prog(q, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    check("run_cpu_rst", 32'(cpu_rst), 32'd0);
    check("run_count", cycle_count, 32'd3);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_run_flags", {29'd0, busy, done, timeout}, 32'd0);
    check("abort_run_cpu_rst", 32'(cpu_rst), 32'd1);

    // Asynchronous reset between edges while running
    load_prog(q, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    check("async_cpu_rst", 32'(cpu_rst), 32'd1);
    check("async_count", cycle_count, 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("async_state", 32'(dut.r_state), 32'(ST_IDLE));

    // Randomized programs, some overflowing, relying on memory contents left behind
    for (int t = 0; t < 14; t++) begin
      int len;
      len = $urandom_range(1, 6);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(rand_word(1'b1));
      load_prog(q, len <= WORDS);
      run_prog(r);
      clear_idle(r.cnt);
    end

    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("res_q_empty", 32'(res_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller that sequences the single-cycle RV32 core for bring-up and regression. Streams a program into instruction memory while holding the core in reset, releases it on command, counts retired instructions, and detects termination (halt idiom or cycle limit). It owns the core's reset line and the instruction-memory write port, and observes the core's fetch bus.

## Interface

- `IMEM_WORDS`, default 256: instruction memory depth in 32-bit words. Power of 2, at least 2.
- `MAX_CYCLES`, default 100000: run-cycle limit before timeout. Range 1 to 2^32-1.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `ld_valid` in 1: a load word is offered.
- `ld_ready` out 1: the controller accepts a load word. A transfer occurs when `ld_valid & ld_ready`.
- `ld_data` in 32: instruction word.
- `ld_last` in 1: marks the final word of the program.
- `start` in 1: single-cycle pulse; begins execution.
- `abort` in 1: returns the controller to IDLE from any state.
- `clear` in 1: acknowledges DONE or TIMEOUT.
- `cpu_rst` out 1: synchronous reset to the core. Registered.
- `inst_data` in 32: the core's current fetched instruction (monitor only).
- `imem_we` out 1: instruction-memory write enable.
- `imem_addr` out $clog2(IMEM_WORDS): word index for the write.
- `imem_wdata` out 32: equals `ld_data`.
- `busy` out 1: state is LOAD, LOADED or RUN.
- `done` out 1: state is DONE.
- `timeout` out 1: state is TIMEOUT.
- `load_err` out 1: the last load overflowed memory. Sticky until the next load begins.
- `cycle_count` out 32: instructions retired in the current or last run.

## Operation

- **State machine:** IDLE, LOAD, LOADED, RUN, DONE, TIMEOUT.
- **IDLE**
  - `cpu_rst`=1, `ld_ready`=1.
  - An accepted word is written to index 0, `word_cnt`←1, `load_err`←0, and the state goes to LOAD. If `ld_last` is also set, the state goes directly to LOADED.
  - `start` and `clear` are ignored.
- **LOAD**
  - `cpu_rst`=1, `ld_ready`=1.
  - Each accepted word is written at `word_cnt`, then `word_cnt`++.
  - Accepted with `ld_last` → LOADED.
  - Accepted at `word_cnt`==IMEM_WORDS-1 without `ld_last`: the word is written, `load_err`←1, and the state goes to LOADED. Later words are not accepted.
- **LOADED**
  - `cpu_rst`=1, `ld_ready`=0.
  - `start` → RUN, `cycle_count`←0.
- **RUN**
  - `cpu_rst`=0, `ld_ready`=0.
  - At each edge:
    - If `inst_data`==HALT_INST (32'h0000_0063, `beq x0,x0,0`), go to DONE with no count.
    - Otherwise `cycle_count`++. If the new value equals MAX_CYCLES, go to TIMEOUT.
- **DONE**
  - `cpu_rst`=0. The core spins harmlessly on the halt instruction, and its register file stays inspectable.
  - `clear` → IDLE.
- **TIMEOUT**
  - `cpu_rst`=1.
  - `clear` → IDLE.
- **Abort:** `abort` in any state → IDLE next edge. Abort has priority over `start`, `clear` and load transfers; no write occurs in the abort cycle.
- **Memory write port:** `imem_we` = `ld_valid & ld_ready & !abort` (combinational). `imem_addr` = `word_cnt`.
- **Status counters:** `cycle_count` and `load_err` hold their values through DONE, TIMEOUT and IDLE until the next start or load.

## Timing

- **Reset values:** state IDLE, `cpu_rst`=1, `ld_ready`=1, `imem_we`=0 (given `ld_valid`=0), `word_cnt`=0, `cycle_count`=0, `load_err`=0, `busy`=`done`=`timeout`=0.
- **Reset mid-operation:** all of the above take effect immediately, whatever the current state. Memory contents are untouched.
- **Load throughput:** one word per cycle.
- **Start to first fetch:** `start` is sampled at edge N. `cpu_rst` drops after N; the core's PC is 0 after N, because `cpu_rst` was still 1 at edge N. The first instruction executes in cycle N..N+1.
- **Count semantics:** a program of K non-halt instructions followed by the halt reaches DONE with `cycle_count`=K, one edge after the halt is fetched.
- **Timeout:** entered at the edge where `cycle_count` becomes MAX_CYCLES. `cpu_rst` is asserted from that edge on.

## Structure

- **Package `cpu_ctrl_pkg`:**
  - `run_state_t` enum with the six states.
  - `HALT_INST` constant.
  - Reused by the test bench for state checks.
- **Sub-modules:** none. One FSM plus two counters, in one module.

## Test plan

- **Load then run:** load 3 words (`addi x1,x0,5`; `addi x2,x1,1`; halt) with `ld_last` on word 3, then pulse `start`. Required: writes at indices 0,1,2; DONE with `cycle_count`=2; core registers x1=5, x2=6.
- **Overflow:** with IMEM_WORDS=4, offer 6 words with no `ld_last`. Required: 4 writes; `ld_ready`=0 after the 4th; `load_err`=1; state LOADED.
- **Timeout:** with MAX_CYCLES=10, run a program with no halt (`addi` loop via `beq` back-edge). Required: TIMEOUT after exactly 10 run edges; `cycle_count`=10; `cpu_rst`=1.
- **Abort mid-load and mid-run:** abort asserted with `ld_valid`=1 → no write that cycle, IDLE next edge. Abort with `start` in LOADED → stays out of RUN, returns to IDLE.
- **Async reset in RUN:** assert `rst` between edges. Required: `cpu_rst`=1 and `cycle_count`=0 immediately; state IDLE after `rst` is released.
- **Clear handling:** `clear` in DONE → IDLE, with `cycle_count` held. `clear` in IDLE → no effect.
